// File: rtl/vx_barrier_table.sv
// Local barrier table: tracks per-slot arrivals from warp control and
// releases every waiting warp in a single registered pulse when the last
// expected warp arrives. Duplicate and size-mismatch arrivals raise sticky
// error flags.
module vx_barrier_table #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NW_WIDTH     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bar_valid,
  input  logic [NW_WIDTH-1:0]  bar_wid,
  input  logic [NB_WIDTH-1:0]  bar_id,
  input  logic [NW_WIDTH-1:0]  bar_size_m1,
  output logic                 release_valid,
  output logic [NB_WIDTH-1:0]  release_id,
  output logic [NUM_WARPS-1:0] release_wmask,
  output logic [NUM_WARPS-1:0] stalled_wmask,
  output logic                 err_dup,
  output logic                 err_size
);

  localparam logic [NW_WIDTH-1:0] MAX_M1 = NW_WIDTH'(NUM_WARPS - 1);

  logic [NW_WIDTH-1:0]  cnt_q   [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]  size_q  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] wmask_q [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]  cnt_d   [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]  size_d  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] wmask_d [NUM_BARRIERS];

  logic                 rel_valid_d;
  logic [NB_WIDTH-1:0]  rel_id_d;
  logic [NUM_WARPS-1:0] rel_wmask_d;
  logic [NUM_WARPS-1:0] stalled_d;
  logic                 err_dup_d;
  logic                 err_size_d;

  logic                 req_ok;
  logic                 busy;
  logic [NW_WIDTH-1:0]  req_m1;
  logic [NW_WIDTH-1:0]  lim;
  logic [NUM_WARPS-1:0] wbit;

  // Next-state for slot table, release pulse, stall view and sticky errors
  always_comb begin
    cnt_d       = cnt_q;
    size_d      = size_q;
    wmask_d     = wmask_q;
    rel_valid_d = 1'b0;
    rel_id_d    = '0;
    rel_wmask_d = '0;
    err_dup_d   = err_dup;
    err_size_d  = err_size;
    stalled_d   = '0;

    req_ok = (int'(bar_wid) < NUM_WARPS) && (int'(bar_id) < NUM_BARRIERS);
    wbit   = NUM_WARPS'(1) << bar_wid;
    req_m1 = (bar_size_m1 > MAX_M1) ? MAX_M1 : bar_size_m1;
    busy   = |wmask_q[bar_id];
    lim    = busy ? size_q[bar_id] : req_m1;

    if (bar_valid && req_ok) begin
      if (busy && (req_m1 != size_q[bar_id]))
        err_size_d = 1'b1;
      // stalled_wmask mirrors OR of all slot masks, so it catches re-arrival
      // at the same slot as well as at a different slot.
      if (|(stalled_wmask & wbit)) begin
        err_dup_d = 1'b1;
      end else if (cnt_q[bar_id] == lim) begin
        rel_valid_d     = 1'b1;
        rel_id_d        = bar_id;
        rel_wmask_d     = wmask_q[bar_id] | wbit;
        cnt_d[bar_id]   = '0;
        size_d[bar_id]  = '0;
        wmask_d[bar_id] = '0;
      end else begin
        cnt_d[bar_id]   = cnt_q[bar_id] + NW_WIDTH'(1);
        size_d[bar_id]  = lim;
        wmask_d[bar_id] = wmask_q[bar_id] | wbit;
      end
    end

    for (int unsigned b = 0; b < NUM_BARRIERS; b++)
      stalled_d = stalled_d | wmask_d[b];
  end

  // Register slot state and all outputs; reset drops waiters silently
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
        cnt_q[b]   <= '0;
        size_q[b]  <= '0;
        wmask_q[b] <= '0;
      end
      release_valid <= 1'b0;
      release_id    <= '0;
      release_wmask <= '0;
      stalled_wmask <= '0;
      err_dup       <= 1'b0;
      err_size      <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      size_q        <= size_d;
      wmask_q       <= wmask_d;
      release_valid <= rel_valid_d;
      release_id    <= rel_id_d;
      release_wmask <= rel_wmask_d;
      stalled_wmask <= stalled_d;
      err_dup       <= err_dup_d;
      err_size      <= err_size_d;
    end
  end

endmodule

// File: tb/tb_vx_barrier_table.sv
// Directed bench for vx_barrier_table with hand-computed expectations.
module tb_vx_barrier_table;

  logic       clk = 1'b0;
  logic       reset;
  logic       bar_valid;
  logic [1:0] bar_wid;
  logic [1:0] bar_id;
  logic [1:0] bar_size_m1;
  logic       release_valid;
  logic [1:0] release_id;
  logic [3:0] release_wmask;
  logic [3:0] stalled_wmask;
  logic       err_dup;
  logic       err_size;

  int errors = 0;
  int checks = 0;

  vx_barrier_table #(.NUM_WARPS(4), .NUM_BARRIERS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .bar_valid     (bar_valid),
    .bar_wid       (bar_wid),
    .bar_id        (bar_id),
    .bar_size_m1   (bar_size_m1),
    .release_valid (release_valid),
    .release_id    (release_id),
    .release_wmask (release_wmask),
    .stalled_wmask (stalled_wmask),
    .err_dup       (err_dup),
    .err_size      (err_size)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents one request and returns at the next
  // negedge, when the registered result is visible.
  task automatic arrive(input logic [1:0] w, input logic [1:0] b, input logic [1:0] m1);
    bar_valid = 1'b1; bar_wid = w; bar_id = b; bar_size_m1 = m1;
    @(negedge clk);
    bar_valid = 1'b0;
  endtask

  task automatic idle();
    bar_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; bar_valid = 1'b0; bar_wid = '0; bar_id = '0; bar_size_m1 = '0;
    repeat (3) @(negedge clk);
    check("rst_rv",  32'(release_valid), 0);
    check("rst_rid", 32'(release_id), 0);
    check("rst_rm",  32'(release_wmask), 0);
    check("rst_st",  32'(stalled_wmask), 0);
    check("rst_ed",  32'(err_dup), 0);
    check("rst_es",  32'(err_size), 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: four-warp barrier on slot 0
    arrive(0, 0, 3);
    arrive(1, 0, 3);
    arrive(2, 0, 3);
    check("t1_st", 32'(stalled_wmask), 32'h7);
    check("t1_norel", 32'(release_valid), 0);
    arrive(3, 0, 3);
    check("t1_rv", 32'(release_valid), 1);
    check("t1_rid", 32'(release_id), 0);
    check("t1_rm", 32'(release_wmask), 32'hf);
    check("t1_st0", 32'(stalled_wmask), 0);
    idle();
    check("t1_pulse1", 32'(release_valid), 0);

    // 2: size_m1==0 completes immediately
    arrive(2, 1, 0);
    check("t2_rv", 32'(release_valid), 1);
    check("t2_rid", 32'(release_id), 1);
    check("t2_rm", 32'(release_wmask), 32'h4);
    check("t2_st", 32'(stalled_wmask), 0);
    idle();

    // 3: interleaved slots, back-to-back pulses
    arrive(0, 0, 1);
    arrive(1, 1, 1);
    check("t3_st", 32'(stalled_wmask), 32'h3);
    arrive(2, 0, 1);
    check("t3_rv0", 32'(release_valid), 1);
    check("t3_rid0", 32'(release_id), 0);
    check("t3_rm0", 32'(release_wmask), 32'h5);
    check("t3_st1", 32'(stalled_wmask), 32'h2);
    arrive(3, 1, 1);
    check("t3_rv1", 32'(release_valid), 1);
    check("t3_rid1", 32'(release_id), 1);
    check("t3_rm1", 32'(release_wmask), 32'ha);
    check("t3_st2", 32'(stalled_wmask), 0);
    check("t3_noerr", 32'({err_dup, err_size}), 0);
    idle();

    // 4: duplicate arrival on slot 2
    arrive(0, 2, 2);
    arrive(0, 2, 2);
    check("t4_ed", 32'(err_dup), 1);
    check("t4_st", 32'(stalled_wmask), 32'h1);
    check("t4_norel", 32'(release_valid), 0);
    arrive(1, 2, 2);
    check("t4_norel2", 32'(release_valid), 0);
    arrive(2, 2, 2);
    check("t4_rv", 32'(release_valid), 1);
    check("t4_rid", 32'(release_id), 2);
    check("t4_rm", 32'(release_wmask), 32'h7);
    idle();
    check("t4_sticky", 32'(err_dup), 1);

    // 5: size mismatch, latched size wins
    check("t5_es0", 32'(err_size), 0);
    arrive(0, 3, 1);
    arrive(1, 3, 3);
    check("t5_es", 32'(err_size), 1);
    check("t5_rv", 32'(release_valid), 1);
    check("t5_rid", 32'(release_id), 3);
    check("t5_rm", 32'(release_wmask), 32'h3);
    idle();

    // 6: reset mid-operation, then fresh barrier
    arrive(0, 0, 3);
    arrive(1, 0, 3);
    check("t6_pre", 32'(stalled_wmask), 32'h3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_st", 32'(stalled_wmask), 0);
    check("t6_rv", 32'(release_valid), 0);
    check("t6_err", 32'({err_dup, err_size}), 0);
    arrive(0, 0, 3);
    arrive(1, 0, 3);
    arrive(2, 0, 3);
    check("t6_norel", 32'(release_valid), 0);
    arrive(3, 0, 3);
    check("t6_rv1", 32'(release_valid), 1);
    check("t6_rm", 32'(release_wmask), 32'hf);
    check("t6_st0", 32'(stalled_wmask), 0);
    check("t6_noerr", 32'({err_dup, err_size}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
